// File: rtl/image_read.sv
// image_read: binarizes a streaming CCD frame and captures an H x W window into a flat bit image.
// Optional macro IMAGE_READ_INVERT_EN stores dark pixels (pixvalue < THRESH) as 1 instead of bright ones.

module image_read #(
   parameter int X_START = 311,
   parameter int Y_START = 200,
   parameter int W       = 300,
   parameter int H       = 150,
   parameter int THRESH  = 512
) (
   input  logic                   pixclk,
   input  logic                   RESET,
   input  logic                   cansend,
   input  logic [9:0]             hsync,
   input  logic [9:0]             vsync,
   input  logic [9:0]             pixvalue,
   output logic                   dataready,
   output logic [0:H-1][0:W-1]    image
);

   localparam int RW = $clog2(H);
   localparam int CW = $clog2(W);

   localparam logic [9:0] X_FIRST = 10'(X_START);
   localparam logic [9:0] X_LAST  = 10'(X_START + W - 1);
   localparam logic [9:0] Y_FIRST = 10'(Y_START);
   localparam logic [9:0] Y_LAST  = 10'(Y_START + H - 1);
   localparam logic [9:0] TH      = 10'(THRESH);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t          state;
   state_t          next_state;
   logic            in_window;
   logic            last_pixel;
   logic            past_window;
   logic            pix_bit;
   logic            wr_en;
   logic [RW-1:0]   row;
   logic [CW-1:0]   col;

   assign in_window   = (hsync >= X_FIRST) && (hsync <= X_LAST) &&
                        (vsync >= Y_FIRST) && (vsync <= Y_LAST);
   assign last_pixel  = (hsync == X_LAST) && (vsync == Y_LAST);
   assign past_window = (vsync > Y_LAST);
   assign row         = RW'(vsync - Y_FIRST);
   assign col         = CW'(hsync - X_FIRST);

`ifdef IMAGE_READ_INVERT_EN
   assign pix_bit = (pixvalue < TH);
`else
   assign pix_bit = (pixvalue >= TH);
`endif

   always_comb begin
      // NOTE: every output of this block is given a default first so no path can infer a latch.
      next_state = state;
      wr_en      = 1'b0;
      unique case (state)
         IDLE: begin
            if (cansend) next_state = ARMED;
         end
         ARMED: begin
            if (!cansend)          next_state = IDLE;
            else if (vsync == '0)  next_state = CAPTURE;
         end
         CAPTURE: begin
            // Dropping cansend aborts without writing; the partial image is kept.
            if (!cansend) begin
               next_state = IDLE;
            end else begin
               wr_en = in_window;
               if (last_pixel || past_window) next_state = DONE;
            end
         end
         DONE: begin
            if (!cansend) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge pixclk) begin
      // NOTE: the image store is cleared on reset because consumers rely on an all-zero image after RESET.
      if (RESET) begin
         state     <= IDLE;
         dataready <= 1'b0;
         image     <= '0;
      end else begin
         state     <= next_state;
         dataready <= (next_state == DONE);
         if (wr_en) image[row][col] <= pix_bit;
      end
   end

endmodule

// File: tb/tb_image_read.sv
// tb_image_read: randomized + directed stimulus for image_read, checked every cycle against a
// behavioural frame-capture model; honours IMAGE_READ_INVERT_EN when defined.

module tb_image_read;

   localparam int X0 = 311;
   localparam int Y0 = 200;
   localparam int W  = 300;
   localparam int H  = 150;
   localparam int TH = 512;

`ifdef IMAGE_READ_INVERT_EN
   localparam logic LIGHT = 1'b0;
`else
   localparam logic LIGHT = 1'b1;
`endif
   localparam logic DARK = ~LIGHT;

   logic                 pixclk   = 1'b0;
   logic                 RESET    = 1'b1;
   logic                 cansend  = 1'b0;
   logic [9:0]           hsync    = '0;
   logic [9:0]           vsync    = '0;
   logic [9:0]           pixvalue = '0;
   logic                 dataready;
   logic [0:H-1][0:W-1]  image;

   always #5 pixclk = ~pixclk;

   image_read dut (
      .pixclk    (pixclk),
      .RESET     (RESET),
      .cansend   (cansend),
      .hsync     (hsync),
      .vsync     (vsync),
      .pixvalue  (pixvalue),
      .dataready (dataready),
      .image     (image)
   );

   // Reference model: capture phase, expected image and expected dataready.
   typedef enum {M_IDLE, M_ARMED, M_GRAB, M_HOLD} mphase_t;
   mphase_t              m_ph = M_IDLE;
   logic [0:H-1][0:W-1]  m_img;
   logic                 m_ready = 1'b0;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  cmp_en   = 1'b0;

   function automatic logic stored(input int p);
      return (p >= TH) ? LIGHT : DARK;
   endfunction

   always @(posedge pixclk) begin
      int x;
      int y;
      int p;
      x = int'(hsync);
      y = int'(vsync);
      p = int'(pixvalue);
      if (RESET) begin
         m_ph  = M_IDLE;
         m_img = '0;
      end else if (m_ph == M_IDLE) begin
         if (cansend) m_ph = M_ARMED;
      end else if (!cansend) begin
         m_ph = M_IDLE;
      end else if (m_ph == M_ARMED) begin
         if (y == 0) m_ph = M_GRAB;
      end else if (m_ph == M_GRAB) begin
         if (x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H)
            m_img[y - Y0][x - X0] = stored(p);
         if ((x == X0 + W - 1 && y == Y0 + H - 1) || y >= Y0 + H)
            m_ph = M_HOLD;
      end
      m_ready = (m_ph == M_HOLD);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge pixclk) begin
      if (cmp_en) begin
         check("dataready_model", 32'(dataready), 32'(m_ready));
         n_checks++;
         if (image !== m_img) begin
            int fr;
            int fc;
            fr = -1;
            fc = -1;
            for (int r = 0; r < H && fr < 0; r++)
               for (int c = 0; c < W && fr < 0; c++)
                  if (image[r][c] !== m_img[r][c]) begin
                     fr = r;
                     fc = c;
                  end
            n_fail++;
            $display("FAIL image_model first diff r=%0d c=%0d actual=%b expected=%b",
                     fr, fc, (fr >= 0) ? image[fr][fc] : 1'bx, (fr >= 0) ? m_img[fr][fc] : 1'bx);
         end
      end
   end

   task automatic drive(input logic cs, input int x, input int y, input int p);
      cansend  = cs;
      hsync    = 10'(x);
      vsync    = 10'(y);
      pixvalue = 10'(p);
      @(posedge pixclk);
      #1;
   endtask

   task automatic arm_and_start();
      drive(1'b0, 0, 0, 0);
      drive(1'b1, 0, Y0, 0);
      drive(1'b1, 0, 0, 0);
   endtask

   initial begin
      int x;
      int y;
      int p;
      int sel;
      logic cs;
      int row0_x[4];

      // Reset with coordinates at zero.
      RESET = 1'b1;
      repeat (10) drive(1'b0, 0, 0, 0);
      RESET = 1'b0;
      cmp_en = 1'b1;
      check("reset_dataready", 32'(dataready), 32'(1'b0));
      check("reset_image_zero", 32'(image === '0), 32'(1'b1));

      // Armed but no frame start yet: no writes allowed.
      repeat (3) drive(1'b1, X0, Y0, 1023);
      check("armed_no_write", 32'(image === '0), 32'(1'b1));
      drive(1'b1, X0, 0, 1023);

      // Row 0: six bright pixels, then dark pixels including the last column.
      for (int i = 0; i < 6; i++) drive(1'b1, X0 + i, Y0, 1023);
      row0_x = '{317, 318, 319, 610};
      foreach (row0_x[i]) drive(1'b1, row0_x[i], Y0, 0);
      for (int i = 0; i < 6; i++) check("row0_bright", 32'(image[0][i]), 32'(LIGHT));
      check("row0_c6_dark", 32'(image[0][6]), 32'(DARK));
      check("row0_c7_dark", 32'(image[0][7]), 32'(DARK));
      check("row0_c8_dark", 32'(image[0][8]), 32'(DARK));
      check("row0_c299_dark", 32'(image[0][299]), 32'(DARK));

      // Out-of-window columns at a valid row must not disturb the image.
      for (int xx = 611; xx <= 617; xx++) drive(1'b1, xx, Y0, 1023);
      drive(1'b1, 310, Y0, 1023);
      check("oow_c299_kept", 32'(image[0][299]), 32'(DARK));
      check("oow_c0_kept", 32'(image[0][0]), 32'(LIGHT));
      check("oow_not_ready", 32'(dataready), 32'(1'b0));

      // Completion on the last pixel, which is itself written.
      drive(1'b1, X0 + W - 1, Y0 + H - 1, 1023);
      check("last_pixel_ready", 32'(dataready), 32'(1'b1));
      check("last_pixel_written", 32'(image[H-1][W-1]), 32'(LIGHT));

      // DONE keeps the image frozen.
      repeat (2) drive(1'b1, 317, Y0, 1023);
      check("done_frozen", 32'(image[0][6]), 32'(DARK));
      check("done_ready_held", 32'(dataready), 32'(1'b1));
      drive(1'b0, 0, 0, 0);
      check("release_ready_low", 32'(dataready), 32'(1'b0));

      // Threshold edges, then abort mid-capture: bits retained, no dataready.
      arm_and_start();
      drive(1'b1, X0, Y0 + 1, 512);
      drive(1'b1, X0 + 1, Y0 + 1, 511);
      drive(1'b1, X0 + 7, Y0 + 5, 1023);
      drive(1'b0, 0, Y0 + 5, 0);
      drive(1'b0, 0, 0, 0);
      check("abort_not_ready", 32'(dataready), 32'(1'b0));
      check("thresh_512", 32'(image[1][0]), 32'(LIGHT));
      check("thresh_511", 32'(image[1][1]), 32'(DARK));
      check("abort_retained", 32'(image[5][7]), 32'(LIGHT));

      // Completion by running past the last row.
      arm_and_start();
      drive(1'b1, 400, 300, 0);
      drive(1'b1, 0, Y0 + H, 0);
      check("past_rows_ready", 32'(dataready), 32'(1'b1));
      check("past_rows_write", 32'(image[100][89]), 32'(DARK));
      drive(1'b0, 0, 0, 0);

      // Randomized traffic; cansend drops only with coordinates outside the window.
      repeat (4000) begin
         cs  = ($urandom_range(63) != 0);
         sel = $urandom_range(99);
         x   = 300 + $urandom_range(320);
         if (sel < 3)      y = 0;
         else if (sel < 5) y = Y0 + H + $urandom_range(9);
         else              y = Y0 - 5 + $urandom_range(H + 4);
         sel = $urandom_range(9);
         if (sel == 0)      p = TH - 1;
         else if (sel == 1) p = TH;
         else               p = $urandom_range(1023);
         if (!cs) x = 0;
         drive(cs, x, y, p);
      end

      // Reset in the middle of a capture clears everything.
      arm_and_start();
      drive(1'b1, 320, 250, 1023);
      RESET = 1'b1;
      drive(1'b1, 0, 0, 0);
      RESET = 1'b0;
      check("midreset_image_zero", 32'(image === '0), 32'(1'b1));
      check("midreset_not_ready", 32'(dataready), 32'(1'b0));
      drive(1'b0, 0, 0, 0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
